// File: rtl/note_serial_rx.sv
// Receiver for the 1-wire note/event link. It deserialises start/data/parity/stop
// frames into words and hands them out over an ovalid/oready handshake.
module note_serial_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] odata,
    output logic                 ovalid,
    input  logic                 oready,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] C_FULL    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] C_LASTBIT = BW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parBit;
    logic                 r_parityErr;
    logic                 r_frameErr;
    logic                 r_deliver;
    logic [DATA_BITS-1:0] r_odata;
    logic                 r_ovalid;
    logic                 r_overrun;

    logic                 w_rxS;
    logic                 w_tick;
    logic                 w_parityBad;

    assign w_rxS       = r_sync2;
    assign w_tick      = (r_cnt == '0);
    assign w_parityBad = (^r_shift) ^ r_parBit;

    // rxd is asynchronous; the line idles high so the flops reset to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Counter is loaded with half a bit on the falling edge, then a full bit
    // at every sample, so each sample lands mid-bit without accumulated drift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_parBit    <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
            r_deliver   <= 1'b0;
        end else begin
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
            r_deliver   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxS) begin
                        r_state <= START;
                        r_cnt   <= C_HALF;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_cnt <= C_FULL;
                        if (w_rxS) begin
                            r_state <= IDLE;
                        end else begin
                            r_state  <= DATA;
                            r_bitIdx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_cnt   <= C_FULL;
                        r_shift <= {w_rxS, r_shift[DATA_BITS-1:1]};
                        if (r_bitIdx == C_LASTBIT) begin
                            r_state <= PARITY;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_cnt    <= C_FULL;
                        r_parBit <= w_rxS;
                        r_state  <= STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_cnt <= C_FULL;
                        // A low stop bit outranks a parity mismatch.
                        if (!w_rxS) begin
                            r_frameErr <= 1'b1;
                            r_state    <= BREAK;
                        end else if (w_parityBad) begin
                            r_parityErr <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_deliver <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BREAK: begin
                    if (w_rxS) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The shift register is untouched until the next frame's first data
    // sample, so it can be loaded into the output buffer one clock late.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_odata   <= '0;
            r_ovalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver && (!r_ovalid || oready)) begin
                r_odata  <= r_shift;
                r_ovalid <= 1'b1;
            end else begin
                if (r_deliver) begin
                    r_overrun <= 1'b1;
                end
                if (r_ovalid && oready) begin
                    r_ovalid <= 1'b0;
                end
            end
        end
    end

    assign odata      = r_odata;
    assign ovalid     = r_ovalid;
    assign overrun    = r_overrun;
    assign parity_err = r_parityErr;
    assign frame_err  = r_frameErr;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_note_serial_rx.sv
// Directed bench for note_serial_rx with 8 clocks per bit; each task drives one
// scenario and compares against hand-computed frame timing and data.
module tb_note_serial_rx;

    localparam int N  = 8;
    localparam int DB = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rxd;
    logic          oready;
    logic [DB-1:0] odata;
    logic          ovalid;
    logic          busy;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    int edgeCount   = 0;
    int validCycles = 0;
    int riseCount   = 0;
    int riseEdge    = 0;
    int parCnt      = 0;
    int frmCnt      = 0;
    int ovrCnt      = 0;
    logic [DB-1:0] riseData = '0;
    logic          prevValid = 1'b0;

    note_serial_rx #(.CLKS_PER_BIT(N), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .odata      (odata),
        .ovalid     (ovalid),
        .oready     (oready),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Observes outputs on the falling edge, away from the DUT's update edge.
    always @(negedge clk) begin
        if (ovalid) validCycles <= validCycles + 1;
        if (ovalid && !prevValid) begin
            riseCount <= riseCount + 1;
            riseEdge  <= edgeCount;
            riseData  <= odata;
        end
        prevValid <= ovalid;
        if (parity_err) parCnt <= parCnt + 1;
        if (frame_err)  frmCnt <= frmCnt + 1;
        if (overrun)    ovrCnt <= ovrCnt + 1;
    end

    // Called on a falling edge; returns on the falling edge after the stop bit.
    task automatic sendFrame(input logic [DB-1:0] word, input logic parBit, input logic stopBit);
        logic [DB+2:0] bits;
        bits = {stopBit, parBit, word, 1'b0};
        for (int i = 0; i < DB + 3; i++) begin
            rxd = bits[i];
            repeat (N) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rxd     = 1'b1;
        oready  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ovalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovalid: got %b expected 0", ovalid); end
        checks++;
        if (odata !== '0) begin errors++; $display("[TB] FAIL reset_odata: got %h expected 000", odata); end
        checks++;
        if ({busy, parity_err, frame_err, overrun} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, parity_err, frame_err, overrun});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, ovalid} !== 2'b00) begin errors++; $display("[TB] FAIL idle_after_reset: got %b expected 00", {busy, ovalid}); end
    endtask

    task automatic test_single_frame();
        int r0, v0, e0, start;
        oready = 1'b1;
        r0 = riseCount; v0 = validCycles; e0 = parCnt + frmCnt + ovrCnt;
        start = edgeCount;
        sendFrame(10'h2A5, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (riseCount - r0 !== 1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", riseCount - r0); end
        checks++;
        if (riseEdge !== start + 104) begin errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", riseEdge - start, 104); end
        checks++;
        if (riseData !== 10'h2A5) begin errors++; $display("[TB] FAIL single_data: got %h expected 2a5", riseData); end
        checks++;
        if (validCycles - v0 !== 1) begin errors++; $display("[TB] FAIL single_width: got %0d expected 1", validCycles - v0); end
        checks++;
        if (parCnt + frmCnt + ovrCnt - e0 !== 0) begin errors++; $display("[TB] FAIL single_errs: got %0d expected 0", parCnt + frmCnt + ovrCnt - e0); end
    endtask

    task automatic test_glitch();
        int r0, e0;
        r0 = riseCount; e0 = parCnt + frmCnt + ovrCnt;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_start: got busy=%b expected 1", busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_drop: got busy=%b expected 0", busy); end
        repeat (20) @(negedge clk);
        checks++;
        if ((riseCount - r0 !== 0) || (parCnt + frmCnt + ovrCnt - e0 !== 0)) begin
            errors++; $display("[TB] FAIL glitch_quiet: got words=%0d errs=%0d expected 0 0", riseCount - r0, parCnt + frmCnt + ovrCnt - e0);
        end
    endtask

    task automatic test_parity();
        int r0, p0;
        r0 = riseCount; p0 = parCnt;
        sendFrame(10'h001, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (parCnt - p0 !== 1) begin errors++; $display("[TB] FAIL parity_pulse: got %0d expected 1", parCnt - p0); end
        checks++;
        if (riseCount - r0 !== 0) begin errors++; $display("[TB] FAIL parity_drop: got %0d words expected 0", riseCount - r0); end
        sendFrame(10'h001, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if ((riseCount - r0 !== 1) || (riseData !== 10'h001)) begin
            errors++; $display("[TB] FAIL parity_good: got %0d words data=%h expected 1 001", riseCount - r0, riseData);
        end
        checks++;
        if (parCnt - p0 !== 1) begin errors++; $display("[TB] FAIL parity_noextra: got %0d expected 1", parCnt - p0); end
    endtask

    task automatic test_framing();
        int r0, p0, f0;
        r0 = riseCount; p0 = parCnt; f0 = frmCnt;
        sendFrame(10'h3FF, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checks++;
        if (frmCnt - f0 !== 1) begin errors++; $display("[TB] FAIL frame_pulse: got %0d expected 1", frmCnt - f0); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL frame_break: got busy=%b expected 1", busy); end
        checks++;
        if ((parCnt - p0 !== 0) || (riseCount - r0 !== 0)) begin
            errors++; $display("[TB] FAIL frame_other: got par=%0d words=%0d expected 0 0", parCnt - p0, riseCount - r0);
        end
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL frame_exit: got busy=%b expected 0", busy); end
        sendFrame(10'h155, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if ((riseCount - r0 !== 1) || (riseData !== 10'h155) || (frmCnt - f0 !== 1)) begin
            errors++; $display("[TB] FAIL frame_recover: got words=%0d data=%h ferr=%0d expected 1 155 1", riseCount - r0, riseData, frmCnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        int o0, r0;
        o0 = ovrCnt; r0 = riseCount;
        oready = 1'b0;
        sendFrame(10'h111, 1'b1, 1'b1);
        checks++;
        if ((ovalid !== 1'b1) || (odata !== 10'h111)) begin
            errors++; $display("[TB] FAIL b2b_first: got valid=%b data=%h expected 1 111", ovalid, odata);
        end
        sendFrame(10'h222, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if ((ovalid !== 1'b1) || (odata !== 10'h111)) begin
            errors++; $display("[TB] FAIL b2b_hold: got valid=%b data=%h expected 1 111", ovalid, odata);
        end
        checks++;
        if (ovrCnt - o0 !== 1) begin errors++; $display("[TB] FAIL b2b_overrun: got %0d expected 1", ovrCnt - o0); end
        checks++;
        if (riseCount - r0 !== 1) begin errors++; $display("[TB] FAIL b2b_words: got %0d expected 1", riseCount - r0); end
        oready = 1'b1;
        @(negedge clk);
        checks++;
        if (ovalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_consume: got valid=%b expected 0", ovalid); end
    endtask

    task automatic test_reset_mid_frame();
        int r0, e0, start;
        oready = 1'b0;
        sendFrame(10'h0AA, 1'b0, 1'b1);
        rxd = 1'b0;
        repeat (N) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({busy, ovalid} !== 2'b11) begin errors++; $display("[TB] FAIL mid_pre: got busy/valid=%b expected 11", {busy, ovalid}); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ovalid, busy, parity_err, frame_err, overrun} !== 5'b00000) begin
            errors++; $display("[TB] FAIL mid_async: got %b expected 00000", {ovalid, busy, parity_err, frame_err, overrun});
        end
        checks++;
        if (odata !== '0) begin errors++; $display("[TB] FAIL mid_odata: got %h expected 000", odata); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        oready  = 1'b1;
        repeat (4) @(negedge clk);
        r0 = riseCount; e0 = parCnt + frmCnt + ovrCnt;
        start = edgeCount;
        sendFrame(10'h3C3, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if ((riseCount - r0 !== 1) || (riseData !== 10'h3C3)) begin
            errors++; $display("[TB] FAIL mid_recover: got words=%0d data=%h expected 1 3c3", riseCount - r0, riseData);
        end
        checks++;
        if (riseEdge !== start + 104) begin errors++; $display("[TB] FAIL mid_latency: got %0d expected 104", riseEdge - start); end
        checks++;
        if (parCnt + frmCnt + ovrCnt - e0 !== 0) begin errors++; $display("[TB] FAIL mid_errs: got %0d expected 0", parCnt + frmCnt + ovrCnt - e0); end
    endtask

    initial begin
        reset_n = 1'b0;
        rxd     = 1'b1;
        oready  = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_glitch();
        test_parity();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_serial_rx.md
Name: note_serial_rx

Overview:
- Serial receiver for the note/event link: the opposite end of the 1-wire output stream carrying 10-bit key-event words.
- Deserialises frames from the line and presents each word through the same ovalid/oready handshake the data FIFO uses.
- Sits on the display/remote board in front of the screen or tone logic, and in loopback benches.
- Detects parity, framing and overrun errors and discards bad words.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit (50 MHz / 9600 baud); must be >= 4.
- DATA_BITS, 10, payload width; matches the inputData/odata word.

Ports:
- clk  input  1  system clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line; asynchronous to clk; idles high.
- odata  output  DATA_BITS  received word; stable while ovalid=1.
- ovalid  output  1  odata holds an unconsumed word.
- oready  input  1  consumer accepts; transfer when ovalid&&oready at posedge clk.
- busy  output  1  frame in progress (any state other than IDLE).
- parity_err  output  1  one-cycle pulse: parity mismatch, word dropped.
- frame_err  output  1  one-cycle pulse: stop bit low, word dropped.
- overrun  output  1  one-cycle pulse: good word arrived while buffer full, new word dropped.

Behaviour:
- Reset (async assert, sync release): state=IDLE; odata=0; ovalid=0; busy=0; all error pulses 0; synchroniser flops=1.
- Reset mid-frame aborts the frame with no error pulse. A word held at reset is lost.
- Frame format, LSB first: start(0), DATA_BITS data, even parity bit, stop(1). Even parity means the XOR of data and parity bits is 0.
- rxd passes through a 2-flop synchroniser giving rx_s. All timing is referenced to T0, the first clk in which rx_s=0 while in IDLE.
- Sample points are at T0 + H + k*N clocks, with N=CLKS_PER_BIT and H=floor(N/2):
  - k=0: start bit.
  - k=1..DATA_BITS: data bits.
  - k=DATA_BITS+1: parity.
  - k=DATA_BITS+2: stop.
- The bit-time counter reloads at each sample point, so there is no cumulative drift.
- FSM:
  - IDLE: on rx_s=0 go to START.
  - START: at the k=0 sample, rx_s=1 means a glitch; return to IDLE silently. Otherwise go to DATA.
  - DATA: shift rx_s into the MSB of the shift register at each sample; after DATA_BITS samples go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP:
    - rx_s=0: pulse frame_err and go to BREAK.
    - Parity bad: pulse parity_err and go to IDLE.
    - Otherwise deliver the word and go to IDLE.
  - BREAK: wait for rx_s=1, then go to IDLE. Line held low never produces repeated frames.
- Framing error takes priority over parity error. Only one error pulse fires per frame.
- Delivery happens on the clk after the stop sample:
  - Buffer empty, or being consumed that same cycle (ovalid&&oready): load odata and set ovalid=1.
  - Otherwise: pulse overrun; odata and ovalid are unchanged.
- Handshake:
  - ovalid stays high until ovalid&&oready.
  - ovalid falls the next clk unless a load coincides, in which case it stays high with the new odata.
  - odata never changes while ovalid=1 without a transfer.
  - oready has no effect when ovalid=0.
- A new frame may start the clk after IDLE is re-entered, so back-to-back frames with a one-bit stop are supported.
- The receiver is independent of the consumer: reception continues while the output is stalled.

Test Plan:
- N=8, send 10'h2A5 (parity 1), oready=1 → ovalid=1 for exactly 1 clk with odata=10'h2A5, at T0+4+12*8+1; no error pulses.
- N=8, rxd low for 2 clks then high → no state change beyond START, busy drops by T0+4, ovalid stays 0.
- N=8, send 10'h001 with parity bit 0 → parity_err pulses once, ovalid stays 0. Then send 10'h001 with correct parity → delivered normally.
- N=8, send 10'h3FF with stop bit 0 and hold rxd low 40 clks → one frame_err pulse, FSM in BREAK until rxd high, then 10'h155 received correctly.
- N=8, oready=0, send 10'h111 then 10'h222 back-to-back → odata=10'h111 held, overrun pulses once. Then oready=1 → 10'h111 transferred, ovalid falls.
- Assert reset_n=0 mid-DATA of a frame with ovalid=1 → all outputs 0 asynchronously. After release, the next clean frame is received correctly.
